sync_debounce: RTL and testbench
================================

// Module: sync_debounce
// PURPOSE
//   Conditions a raw asynchronous level (switch, button, off-chip strobe) into a clean,
//   clk-synchronous, debounced level. Output `signal` drives the either-edge detector's
//   `signal` input directly, giving exactly one `ed` pulse per accepted transition.
//   Sits between the pad/input buffer and the edge detector.
// PARAMETERS
//   SYNC_STAGES    2   synchronizer flop count; >=2, elaboration $error otherwise
//   STABLE_CYCLES  4   consecutive cycles sync_out must differ from signal before acceptance; >=1
//   RESET_LEVEL    1'b0  value of sync flops and `signal` while in reset
//   GLITCH_W       8   width of glitch_cnt (only with DEB_GLITCH_CNT_EN); >=1
// PORTS
//   clk           input   1         single clock, all logic posedge
//   rst_n         input   1         asynchronous, active-low reset
//   signal_async  input   1         raw asynchronous level, no timing relation to clk
//   signal        output  1         debounced synchronous level, registered
//   busy          output  1         1 while a candidate transition is being qualified
//   glitch_cnt    output  GLITCH_W  rejected transitions, saturating (DEB_GLITCH_CNT_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0, async assert, sync deassert via flops): sync chain=RESET_LEVEL,
//     signal=RESET_LEVEL, cnt=0, state=DEB_IDLE, busy=0, glitch_cnt=0. Mid-qualification reset
//     aborts the count; no partial transition is ever output.
//   - sync_out = last sync stage; only sync_out feeds debounce logic (no raw-input paths).
//   - cnt width $clog2(STABLE_CYCLES+1). Per posedge:
//     DEB_IDLE: sync_out==signal -> stay. sync_out!=signal -> if STABLE_CYCLES==1 signal<=sync_out
//       (stay IDLE) else cnt<=1, ->DEB_PENDING.
//     DEB_PENDING: sync_out==signal -> cnt<=0, ->DEB_IDLE, glitch event.
//       sync_out!=signal and cnt==STABLE_CYCLES-1 -> signal<=sync_out, cnt<=0, ->DEB_IDLE.
//       else cnt<=cnt+1.
//   - busy = (state==DEB_PENDING), registered-state decode, no input comb path.
//   - Latency: new level first sampled at posedge E1, held -> signal changes at
//     E(SYNC_STAGES+STABLE_CYCLES) (defaults: E6). Same latency both polarities.
//   - Acceptance: a level run of W cycles at sync_out is accepted iff W>=STABLE_CYCLES;
//     accepted pulse reproduced at signal with width W (rise/fall latency equal).
//   - signal toggles at most once per STABLE_CYCLES cycles; never changes in reset.
// CONFIGURATION
//   DEB_GLITCH_CNT_EN defined: glitch_cnt port present; +1 per glitch event, saturates at
//     2**GLITCH_W-1, never wraps, cleared only by reset.
//   Undefined: glitch_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//   debounce_pkg: typedef enum logic {DEB_IDLE, DEB_PENDING} deb_state_e; localparam
//     DEB_MIN_SYNC_STAGES=2.
//   Sub-module sync_chain #(STAGES, RESET_VAL) (clk, rst_n, d, q): N-flop synchronizer,
//     no logic between flops; reused by other CDC inputs.
//   sync_debounce = sync_chain + state/cnt registers + optional glitch counter.
// TESTING (defaults unless stated; eed instanced downstream on `signal`)
//   1 Reset: rst_n=0, signal_async=1 -> signal=0,busy=0,glitch_cnt=0; release, hold 1 ->
//     signal rises at E6, busy high E3..E5, one ed pulse after.
//   2 Glitch: 3-cycle high pulse -> signal stays 0, busy high 3 cycles, glitch_cnt=1, no ed.
//   3 Threshold: 4-cycle pulse -> signal high exactly 4 cycles, two ed pulses;
//     3-cycle pulse rejected.
//   4 Reset mid-count: rst_n low during DEB_PENDING with cnt=2 -> busy=0, signal=0 immediately;
//     after release, input still 1 -> full E6 latency restarts.
//   5 RESET_LEVEL=1, STABLE_CYCLES=1: after reset signal=1; drive 0 -> signal falls at E3.
//   6 GLITCH_W=2, 5 glitches -> glitch_cnt 1,2,3,3,3; build without macro compiles, no port.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce slice.
//   deb_state_e         : debounce FSM state encoding
//   DEB_MIN_SYNC_STAGES : minimum synchronizer depth accepted by sync_debounce
//   deb_cnt_width()     : qualification counter width for a given stable-cycle count
package debounce_pkg;

    typedef enum logic {
        DEB_IDLE    = 1'b0,
        DEB_PENDING = 1'b1
    } deb_state_e;

    localparam int unsigned DEB_MIN_SYNC_STAGES = 2;

    // Counter must be able to hold the value STABLE_CYCLES.
    function automatic int unsigned deb_cnt_width(input int unsigned stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage : debounce_pkg

// File: rtl/sync_debounce_sync_chain.sv
// sync_chain: plain N-flop synchronizer for a single-bit asynchronous input.
// No logic between the flops, so the chain can be reused for any CDC level input.
// Asynchronous active-low reset loads RESET_VAL into every stage.
module sync_chain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_chain: STAGES must be >= 2");
            // Shift the raw input into a single flop so the build still closes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= {STAGES{RESET_VAL}};
                end else begin
                    r_sync <= {STAGES{d}};
                end
            end
        end else begin : g_chain
            // Shift the raw input through the flop chain, stage 0 first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= {STAGES{RESET_VAL}};
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], d};
                end
            end
        end
    endgenerate

    assign q = r_sync[STAGES-1];

endmodule : sync_chain

// File: rtl/sync_debounce.sv
// sync_debounce: synchronizes a raw asynchronous level and only passes a new level
// to `signal` after it has been stable for STABLE_CYCLES consecutive cycles at the
// synchronizer output. Rise and fall latency are identical (SYNC_STAGES+STABLE_CYCLES).
// Optional feature macro DEB_GLITCH_CNT_EN: adds the glitch_cnt port, a saturating
// count of candidate transitions that were rejected.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                signal_async,
    output logic                signal,
    output logic                busy
`ifdef DEB_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int unsigned    CNT_W    = deb_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((STABLE_CYCLES < 1) ? 0 : STABLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < DEB_MIN_SYNC_STAGES) begin : g_chk_sync
            $error("sync_debounce: SYNC_STAGES must be >= %0d", DEB_MIN_SYNC_STAGES);
        end
        if (STABLE_CYCLES < 1) begin : g_chk_stable
            $error("sync_debounce: STABLE_CYCLES must be >= 1");
        end
        if (GLITCH_W < 1) begin : g_chk_glitch
            $error("sync_debounce: GLITCH_W must be >= 1");
        end
    endgenerate

    logic        w_sync_out;
    deb_state_e  r_state;
    deb_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic        r_signal;
    logic        w_signal_nxt;
    logic        w_differs;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal_async),
        .q     (w_sync_out)
    );

    assign w_differs = (w_sync_out != r_signal);

    // Qualify a candidate level: count consecutive differing cycles, accept on the last one.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_signal_nxt = r_signal;
        unique case (r_state)
            DEB_IDLE: begin
                if (w_differs) begin
                    if (STABLE_CYCLES == 1) begin
                        w_signal_nxt = w_sync_out;
                    end else begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = DEB_PENDING;
                    end
                end
            end
            DEB_PENDING: begin
                if (!w_differs) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DEB_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_signal_nxt = w_sync_out;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = DEB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = DEB_IDLE;
            end
        endcase
    end

    // State, counter and output level registers; reset aborts any qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= DEB_IDLE;
            r_cnt    <= '0;
            r_signal <= RESET_LEVEL;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_signal <= w_signal_nxt;
        end
    end

    assign signal = r_signal;
    assign busy   = (r_state == DEB_PENDING);

`ifdef DEB_GLITCH_CNT_EN
    logic                w_glitch;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    // A candidate abandoned before acceptance is a glitch.
    assign w_glitch = (r_state == DEB_PENDING) && !w_differs;

    // Saturating glitch counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule : sync_debounce

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default instance plus a RESET_LEVEL=1,
// STABLE_CYCLES=1 instance and a GLITCH_W=2 instance sharing the default stimulus.
// Edge pulses (what a downstream either-edge detector would emit) are counted from
// toggles of the default instance's `signal`.
module tb_sync_debounce;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sig_a = 1'b1;
    logic sig_b = 1'b1;

    logic sig0, busy0, sig1, busy1, sig2, busy2;
`ifdef DEB_GLITCH_CNT_EN
    logic [7:0] gc0;
    logic [7:0] gc1;
    logic [1:0] gc2;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ed_cnt   = 0;
    logic prev_sig0 = 1'b0;

    always #5 clk = ~clk;

    sync_debounce u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_async (sig_a),
        .signal       (sig0),
        .busy         (busy0)
`ifdef DEB_GLITCH_CNT_EN
        ,.glitch_cnt  (gc0)
`endif
    );

    sync_debounce #(
        .STABLE_CYCLES (1),
        .RESET_LEVEL   (1'b1)
    ) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_async (sig_b),
        .signal       (sig1),
        .busy         (busy1)
`ifdef DEB_GLITCH_CNT_EN
        ,.glitch_cnt  (gc1)
`endif
    );

    sync_debounce #(
        .GLITCH_W (2)
    ) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_async (sig_a),
        .signal       (sig2),
        .busy         (busy2)
`ifdef DEB_GLITCH_CNT_EN
        ,.glitch_cnt  (gc2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; tally output toggles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sig0 !== prev_sig0) ed_cnt++;
        prev_sig0 = sig0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1 / 5: reset values, then rise latency (dut0) and fall latency (dut1).
        tick();
        tick();
        check_eq("rst_sig0", sig0, 0);
        check_eq("rst_busy0", busy0, 0);
        check_eq("rst_sig1", sig1, 1);
        check_eq("rst_busy1", busy1, 0);
`ifdef DEB_GLITCH_CNT_EN
        check_eq("rst_gc0", gc0, 0);
`endif
        rst_n = 1'b1;
        sig_b = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq($sformatf("t1_sig_E%0d", i), sig0, (i >= 6) ? 1 : 0);
            check_eq($sformatf("t1_busy_E%0d", i), busy0, (i >= 3 && i <= 5) ? 1 : 0);
            check_eq($sformatf("t5_sig1_E%0d", i), sig1, (i < 3) ? 1 : 0);
            check_eq($sformatf("t5_busy1_E%0d", i), busy1, 0);
        end
        check_eq("t1_ed", ed_cnt, 1);

        sig_a = 1'b0;
        repeat (8) tick();
        check_eq("settle0_sig", sig0, 0);
        check_eq("settle0_ed", ed_cnt, 2);

        // Test 2: 3-cycle pulse is rejected.
        for (int i = 1; i <= 8; i++) begin
            sig_a = (i <= 3);
            tick();
            check_eq($sformatf("t2_sig_E%0d", i), sig0, 0);
            check_eq($sformatf("t2_busy_E%0d", i), busy0, (i >= 3 && i <= 5) ? 1 : 0);
        end
        check_eq("t2_ed", ed_cnt, 2);
`ifdef DEB_GLITCH_CNT_EN
        check_eq("t2_gc0", gc0, 1);
`endif

        // Test 3: 4-cycle pulse is reproduced with width 4.
        for (int i = 1; i <= 12; i++) begin
            sig_a = (i <= 4);
            tick();
            check_eq($sformatf("t3_sig_E%0d", i), sig0, (i >= 6 && i <= 9) ? 1 : 0);
            check_eq($sformatf("t3_busy_E%0d", i), busy0,
                     ((i >= 3 && i <= 5) || (i >= 7 && i <= 9)) ? 1 : 0);
        end
        check_eq("t3_ed", ed_cnt, 4);
`ifdef DEB_GLITCH_CNT_EN
        check_eq("t3_gc0", gc0, 1);
`endif

        // Test 4: reset during qualification with cnt=2.
        sig_a = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        check_eq("t4_busy_pre", busy0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t4_busy_rst", busy0, 0);
        check_eq("t4_sig_rst", sig0, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq($sformatf("t4_sig_E%0d", i), sig0, (i >= 6) ? 1 : 0);
            check_eq($sformatf("t4_busy_E%0d", i), busy0, (i >= 3 && i <= 5) ? 1 : 0);
        end
        check_eq("t4_ed", ed_cnt, 5);
`ifdef DEB_GLITCH_CNT_EN
        check_eq("t4_gc0", gc0, 0);
        check_eq("t4_gc2", gc2, 0);
`endif
        sig_a = 1'b0;
        repeat (8) tick();
        check_eq("settle1_sig", sig0, 0);

        // Test 6: five 2-cycle glitches; GLITCH_W=2 instance saturates at 3.
        for (int k = 1; k <= 5; k++) begin
            for (int i = 1; i <= 10; i++) begin
                sig_a = (i <= 2);
                tick();
            end
            check_eq($sformatf("t6_sig_g%0d", k), sig0, 0);
            check_eq($sformatf("t6_sig2_g%0d", k), sig2, 0);
`ifdef DEB_GLITCH_CNT_EN
            check_eq($sformatf("t6_gc0_g%0d", k), gc0, k);
            check_eq($sformatf("t6_gc2_g%0d", k), gc2, (k < 3) ? k : 3);
`endif
        end
        check_eq("t6_ed", ed_cnt, 6);
        check_eq("t6_busy", busy0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_debounce
